// File: rtl/load_unit.sv
// rtl/load_unit.sv - multi-cycle load-word datapath: decode, address, memory read, register writeback
module load_unit #(
    parameter logic [5:0]  LW_OPCODE = 6'b100011,
    parameter int unsigned MAX_WAIT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] instruction,
    input  logic [31:0] Read_data1,
    output logic        busy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        RegWrite,
    output logic [4:0]  Write_reg,
    output logic [31:0] Write_data,
    output logic        done,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_REQ,
        S_WB,
        S_FAULT
    } state_t;

    // Counter value seen on the edge that exhausts the REQ wait budget.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [4:0]  rt_q, rt_d;
    logic [15:0] imm_q, imm_d;
    logic [31:0] base_q, base_d;
    logic [7:0]  wait_q, wait_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        done_q, done_d;
    logic        regwrite_q, regwrite_d;
    logic        fault_q, fault_d;
    logic [4:0]  write_reg_q, write_reg_d;
    logic [31:0] write_data_q, write_data_d;
    logic [31:0] addr_sum;

    assign addr_sum = base_q + {{16{imm_q[15]}}, imm_q};

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rt_d         = rt_q;
        imm_d        = imm_q;
        base_d       = base_q;
        wait_d       = wait_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        done_d       = 1'b0;
        regwrite_d   = 1'b0;
        fault_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = instruction[31:26];
                    rt_d    = instruction[20:16];
                    imm_d   = instruction[15:0];
                    base_d  = Read_data1;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if ((op_q != LW_OPCODE) || (addr_sum[1:0] != 2'b00)) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = addr_sum;
                    wait_d     = 8'd0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                // An ack on the final budget edge takes priority over the timeout.
                if (mem_ack) begin
                    mem_req_d    = 1'b0;
                    done_d       = 1'b1;
                    regwrite_d   = (rt_q != 5'd0);
                    write_reg_d  = rt_q;
                    write_data_d = mem_rdata;
                    state_d      = S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    mem_req_d = 1'b0;
                    fault_d   = 1'b1;
                    state_d   = S_FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB:    state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= 6'd0;
            rt_q         <= 5'd0;
            imm_q        <= 16'd0;
            base_q       <= 32'd0;
            wait_q       <= 8'd0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= 32'd0;
            done_q       <= 1'b0;
            regwrite_q   <= 1'b0;
            fault_q      <= 1'b0;
            write_reg_q  <= 5'd0;
            write_data_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rt_q         <= rt_d;
            imm_q        <= imm_d;
            base_q       <= base_d;
            wait_q       <= wait_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            done_q       <= done_d;
            regwrite_q   <= regwrite_d;
            fault_q      <= fault_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign RegWrite   = regwrite_q;
    assign Write_reg  = write_reg_q;
    assign Write_data = write_data_q;
    assign done       = done_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - directed self-checking bench for load_unit
module tb_load_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] instruction;
    logic [31:0] Read_data1;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        RegWrite;
    logic [4:0]  Write_reg;
    logic [31:0] Write_data;
    logic        done;
    logic        fault;

    int tests = 0;
    int fails = 0;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    load_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .instruction (instruction),
        .Read_data1  (Read_data1),
        .busy        (busy),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .RegWrite    (RegWrite),
        .Write_reg   (Write_reg),
        .Write_data  (Write_data),
        .done        (done),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a start for one edge; afterwards the unit is in ADDR.
    task automatic issue(input logic [5:0] op, input logic [4:0] rt,
                         input logic [31:0] base, input logic [15:0] imm);
        start       = 1'b1;
        instruction = {op, 5'd3, rt, imm};
        Read_data1  = base;
        step();
        start       = 1'b0;
        instruction = 32'd0;
        Read_data1  = 32'd0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; instruction = 32'd0; Read_data1 = 32'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        step(); step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_outs", {27'd0, RegWrite, done, fault, 2'b00}, 32'd0);
        check("rst_wreg", {27'd0, Write_reg}, 32'd0);
        check("rst_wdata", Write_data, 32'd0);
        reset = 1'b0;
        step();

        // 1: basic load, zero-wait memory
        issue(OP_LW, 5'd5, 32'h0000_1000, 16'h0004);
        check("t1_busy_addr", {31'd0, busy}, 32'd1);
        check("t1_noreq_addr", {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        check("t1_req", {31'd0, mem_req}, 32'd1);
        check("t1_addr", mem_addr, 32'h0000_1004);
        check("t1_done_early", {31'd0, done}, 32'd0);
        step();
        mem_ack = 1'b0; mem_rdata = 32'd0;
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_regwrite", {31'd0, RegWrite}, 32'd1);
        check("t1_req_drop", {31'd0, mem_req}, 32'd0);
        check("t1_wreg", {27'd0, Write_reg}, 32'd5);
        check("t1_wdata", Write_data, 32'hDEAD_BEEF);
        check("t1_busy_wb", {31'd0, busy}, 32'd1);
        step();
        check("t1_idle", {30'd0, busy, done}, 32'd0);
        check("t1_hold_wdata", Write_data, 32'hDEAD_BEEF);

        // 2: negative offset, then wraparound issued in the first idle cycle
        issue(OP_LW, 5'd7, 32'h0000_1000, 16'hFFFC);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        check("t2_addr_neg", mem_addr, 32'h0000_0FFC);
        step();
        mem_ack = 1'b0;
        check("t2_done_neg", {31'd0, done}, 32'd1);
        check("t2_wdata_neg", Write_data, 32'h1234_5678);
        step();
        check("t2_idle", {31'd0, busy}, 32'd0);
        issue(OP_LW, 5'd9, 32'hFFFF_FFFC, 16'h0008);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
        step();
        check("t2_addr_wrap", mem_addr, 32'h0000_0004);
        step();
        mem_ack = 1'b0;
        check("t2_done_wrap", {30'd0, done, RegWrite}, 32'd3);
        check("t2_wreg_wrap", {27'd0, Write_reg}, 32'd9);
        check("t2_wdata_wrap", Write_data, 32'hCAFE_0001);
        step();

        // 3: misaligned address, then wrong opcode
        issue(OP_LW, 5'd4, 32'h0000_1000, 16'h0002);
        mem_ack = 1'b1;
        check("t3_noreq0", {31'd0, mem_req}, 32'd0);
        step();
        check("t3_fault", {31'd0, fault}, 32'd1);
        check("t3_noreq1", {31'd0, mem_req}, 32'd0);
        check("t3_nodone", {30'd0, done, RegWrite}, 32'd0);
        check("t3_busy1", {31'd0, busy}, 32'd1);
        step();
        mem_ack = 1'b0;
        check("t3_busy_low", {31'd0, busy}, 32'd0);
        check("t3_fault_pulse", {31'd0, fault}, 32'd0);
        check("t3_wdata_kept", Write_data, 32'hCAFE_0001);
        issue(OP_SW, 5'd4, 32'h0000_1000, 16'h0004);
        step();
        check("t3_op_fault", {29'd0, fault, mem_req, done}, 32'd4);
        step();
        check("t3_op_idle", {31'd0, busy}, 32'd0);

        // 4a: ack after three wait cycles
        issue(OP_LW, 5'd6, 32'h0000_2000, 16'h0010);
        step();
        for (int i = 0; i < 3; i++) begin
            check("t4_req_wait", {31'd0, mem_req}, 32'd1);
            check("t4_addr_stable", mem_addr, 32'h0000_2010);
            step();
        end
        check("t4_req_4th", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hA5A5_0F0F;
        step();
        mem_ack = 1'b0;
        check("t4_done", {29'd0, done, RegWrite, mem_req}, 32'd6);
        check("t4_wdata", Write_data, 32'hA5A5_0F0F);
        step();

        // 4b: no ack, timeout on the 15th REQ edge
        issue(OP_LW, 5'd6, 32'h0000_3000, 16'h0000);
        step();
        for (int i = 0; i < 14; i++) step();
        check("t4_to_pending", {30'd0, mem_req, fault}, 32'd2);
        step();
        check("t4_to_fault", {29'd0, fault, mem_req, done}, 32'd4);
        step();
        check("t4_to_idle", {30'd0, busy, fault}, 32'd0);

        // 4c: ack arrives exactly on the 15th REQ edge
        issue(OP_LW, 5'd8, 32'h0000_3000, 16'h0020);
        step();
        for (int i = 0; i < 14; i++) step();
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        step();
        mem_ack = 1'b0;
        check("t4_last_ack", {30'd0, done, fault}, 32'd2);
        check("t4_last_data", Write_data, 32'h0BAD_F00D);
        step();

        // 5: rt=0 suppresses RegWrite; start during REQ ignored
        issue(OP_LW, 5'd0, 32'h0000_4000, 16'h0000);
        step();
        start = 1'b1; instruction = {OP_LW, 5'd1, 5'd12, 16'h0100}; Read_data1 = 32'h0000_5000;
        step();
        start = 1'b0;
        check("t5_addr_kept", mem_addr, 32'h0000_4000);
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        mem_ack = 1'b0;
        check("t5_rt0", {30'd0, done, RegWrite}, 32'd2);
        check("t5_wreg0", {27'd0, Write_reg}, 32'd0);
        step();
        step();
        check("t5_single", {30'd0, busy, mem_req}, 32'd0);

        // 6: reset while in REQ, then a fresh load
        issue(OP_LW, 5'd10, 32'h0000_6000, 16'h0008);
        step();
        check("t6_in_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        check("t6_rst_ctl", {27'd0, busy, mem_req, RegWrite, done, fault}, 32'd0);
        check("t6_rst_data", Write_data, 32'd0);
        check("t6_rst_addr", mem_addr, 32'd0);
        step();
        mem_ack = 1'b0;
        check("t6_no_done", {30'd0, done, busy}, 32'd0);
        issue(OP_LW, 5'd11, 32'h0000_7000, 16'h000C);
        mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
        step();
        check("t6_fresh_addr", mem_addr, 32'h0000_700C);
        step();
        mem_ack = 1'b0;
        check("t6_fresh_done", {30'd0, done, RegWrite}, 32'd3);
        check("t6_fresh_data", Write_data, 32'h3333_4444);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
